// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter: shares one data memory between the MEM stage (A) and the DMA
// port (B), with priority to A, a starvation guard and a B burst lock.
// Revision: 1.0
// ============================================================================
module mem_arbiter #(
   parameter int XLEN         = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            a_req,
   input  logic [XLEN-1:0] a_addr,
   input  logic [XLEN-1:0] a_wdata,
   input  logic            a_write,
   input  logic [1:0]      a_size,
   input  logic            a_unsigned,
   output logic            a_gnt,
   output logic            a_rvalid,
   output logic [XLEN-1:0] a_rdata,
   input  logic            b_req,
   input  logic [XLEN-1:0] b_addr,
   input  logic [XLEN-1:0] b_wdata,
   input  logic            b_write,
   input  logic [1:0]      b_size,
   input  logic            b_unsigned,
   input  logic            b_lock,
   output logic            b_gnt,
   output logic            b_rvalid,
   output logic [XLEN-1:0] b_rdata,
   output logic            mem_en,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_write_data,
   output logic            mem_write,
   output logic [1:0]      mem_size,
   output logic            mem_load_unsigned,
   input  logic [XLEN-1:0] mem_read_data
);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      B_LOCK = 1'b1
   } state_t;

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   state_t     state_q, state_d;
   logic [3:0] starve_cnt_q, starve_cnt_d;
   logic       a_rvalid_q, a_rvalid_d;
   logic       b_rvalid_q, b_rvalid_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         starve_cnt_q <= '0;
         a_rvalid_q   <= 1'b0;
         b_rvalid_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         a_rvalid_q   <= a_rvalid_d;
         b_rvalid_q   <= b_rvalid_d;
      end
   end

   // Grants are suppressed while rst is high so nothing reaches memory in reset.
   always_comb begin
      a_gnt   = 1'b0;
      b_gnt   = 1'b0;
      state_d = state_q;
      if (!rst) begin
         case (state_q)
            IDLE: begin
               if (b_req && (starve_cnt_q == STARVE_MAX)) b_gnt = 1'b1;
               else if (a_req)                            a_gnt = 1'b1;
               else if (b_req)                            b_gnt = 1'b1;
               if (b_gnt && b_lock) state_d = B_LOCK;
            end
            B_LOCK: begin
               b_gnt = b_req;
               if (!(b_req && b_lock)) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (b_gnt || !b_req || (state_q == B_LOCK)) starve_cnt_d = '0;
      else if (a_gnt && (starve_cnt_q != STARVE_MAX)) starve_cnt_d = starve_cnt_q + 4'd1;
   end

   always_comb begin
      a_rvalid_d = a_gnt && !a_write;
      b_rvalid_d = b_gnt && !b_write;
   end

   always_comb begin
      mem_en            = a_gnt | b_gnt;
      mem_addr          = '0;
      mem_write_data    = '0;
      mem_write         = 1'b0;
      mem_size          = 2'b00;
      mem_load_unsigned = 1'b0;
      if (a_gnt) begin
         mem_addr          = a_addr;
         mem_write_data    = a_wdata;
         mem_write         = a_write;
         mem_size          = a_size;
         mem_load_unsigned = a_unsigned;
      end else if (b_gnt) begin
         mem_addr          = b_addr;
         mem_write_data    = b_wdata;
         mem_write         = b_write;
         mem_size          = b_size;
         mem_load_unsigned = b_unsigned;
      end
   end

   // An outstanding load is dropped as soon as rst is seen, not one edge later.
   always_comb begin
      a_rvalid = a_rvalid_q && !rst;
      b_rvalid = b_rvalid_q && !rst;
      a_rdata  = a_rvalid ? mem_read_data : '0;
      b_rdata  = b_rvalid ? mem_read_data : '0;
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a small
// byte-addressed memory model. Revision: 1.0
// ============================================================================
module tb_mem_arbiter;

   localparam logic [1:0] SZ8  = 2'd0;
   localparam logic [1:0] SZ16 = 2'd1;
   localparam logic [1:0] SZ32 = 2'd2;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_req, a_write, a_unsigned, a_gnt, a_rvalid;
   logic [31:0] a_addr, a_wdata, a_rdata;
   logic [1:0]  a_size;
   logic        b_req, b_write, b_unsigned, b_lock, b_gnt, b_rvalid;
   logic [31:0] b_addr, b_wdata, b_rdata;
   logic [1:0]  b_size;
   logic        mem_en, mem_write, mem_load_unsigned;
   logic [31:0] mem_addr, mem_write_data, mem_read_data;
   logic [1:0]  mem_size;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem [256];

   always #5 clk = ~clk;

   mem_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_addr(a_addr), .a_wdata(a_wdata), .a_write(a_write),
      .a_size(a_size), .a_unsigned(a_unsigned), .a_gnt(a_gnt),
      .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_addr(b_addr), .b_wdata(b_wdata), .b_write(b_write),
      .b_size(b_size), .b_unsigned(b_unsigned), .b_lock(b_lock), .b_gnt(b_gnt),
      .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
      .mem_write(mem_write), .mem_size(mem_size),
      .mem_load_unsigned(mem_load_unsigned), .mem_read_data(mem_read_data)
   );

   function automatic logic [31:0] load_val(input logic [7:0] a, input logic [1:0] sz, input logic uns);
      logic [31:0] w;
      w = {mem[8'(a + 8'd3)], mem[8'(a + 8'd2)], mem[8'(a + 8'd1)], mem[a]};
      case (sz)
         SZ8:     return uns ? {24'h0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
         SZ16:    return uns ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
         default: return w;
      endcase
   endfunction

   // Memory model: registered read, store visible on the next cycle.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_write) begin
            mem[mem_addr[7:0]] <= mem_write_data[7:0];
            if (mem_size != SZ8) mem[8'(mem_addr[7:0] + 8'd1)] <= mem_write_data[15:8];
            if (mem_size == SZ32) begin
               mem[8'(mem_addr[7:0] + 8'd2)] <= mem_write_data[23:16];
               mem[8'(mem_addr[7:0] + 8'd3)] <= mem_write_data[31:24];
            end
         end else begin
            mem_read_data <= load_val(mem_addr[7:0], mem_size, mem_load_unsigned);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drv_a(input logic req, input logic [31:0] addr, input logic [31:0] wd,
                        input logic wr, input logic [1:0] sz, input logic uns);
      a_req = req; a_addr = addr; a_wdata = wd; a_write = wr; a_size = sz; a_unsigned = uns;
   endtask

   task automatic drv_b(input logic req, input logic [31:0] addr, input logic [31:0] wd,
                        input logic wr, input logic [1:0] sz, input logic uns, input logic lck);
      b_req = req; b_addr = addr; b_wdata = wd; b_write = wr; b_size = sz; b_unsigned = uns;
      b_lock = lck;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [9:0] exp_b;
      mem_read_data = '0;
      rst = 1'b1;
      drv_a(1, 32'h10, 0, 0, SZ32, 0);
      drv_b(1, 32'h10, 0, 0, SZ32, 0, 0);

      // Reset held two cycles with both ports requesting
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rst_a_gnt", 32'(a_gnt), 0);
         chk("rst_b_gnt", 32'(b_gnt), 0);
         chk("rst_mem_en", 32'(mem_en), 0);
         chk("rst_a_rvalid", 32'(a_rvalid), 0);
         chk("rst_b_rvalid", 32'(b_rvalid), 0);
         chk("rst_starve", 32'(dut.starve_cnt_q), 0);
      end

      next_cycle();
      rst = 1'b0;
      drv_a(0, 32'h1234, 32'h5678, 1, SZ32, 1);
      drv_b(0, 32'h4321, 32'h8765, 1, SZ16, 1, 0);
      @(negedge clk);
      chk("idle_mem_en", 32'(mem_en), 0);
      chk("idle_mem_addr", mem_addr, 0);
      chk("idle_mem_wdata", mem_write_data, 0);
      chk("idle_mem_write", 32'(mem_write), 0);
      chk("idle_mem_size", 32'(mem_size), 0);
      chk("idle_mem_uns", 32'(mem_load_unsigned), 0);

      // Cross-port coherence: B stores, A loads it back
      next_cycle();
      drv_b(1, 32'h10, 32'hDEADBEEF, 1, SZ32, 0, 0);
      @(negedge clk);
      chk("coh_b_gnt", 32'(b_gnt), 1);
      chk("coh_a_gnt0", 32'(a_gnt), 0);
      chk("coh_mem_write", 32'(mem_write), 1);
      chk("coh_mem_addr", mem_addr, 32'h10);
      chk("coh_mem_wdata", mem_write_data, 32'hDEADBEEF);
      next_cycle();
      drv_b(0, 0, 0, 0, SZ32, 0, 0);
      drv_a(1, 32'h10, 0, 0, SZ32, 0);
      @(negedge clk);
      chk("coh_a_gnt", 32'(a_gnt), 1);
      chk("coh_store_no_rvalid", 32'(b_rvalid), 0);
      next_cycle();
      drv_a(0, 0, 0, 0, SZ32, 0);
      @(negedge clk);
      chk("coh_a_rvalid", 32'(a_rvalid), 1);
      chk("coh_a_rdata", a_rdata, 32'hDEADBEEF);
      chk("coh_b_rvalid", 32'(b_rvalid), 0);
      chk("coh_b_rdata", b_rdata, 0);

      // Setup for simultaneous loads
      next_cycle();
      drv_a(1, 32'h8, 32'h0000_8000, 1, SZ16, 0);
      next_cycle();
      drv_a(1, 32'hC, 32'h0000_0080, 1, SZ8, 0);
      @(negedge clk);
      chk("setup_mem_size", 32'(mem_size), 32'(SZ8));

      next_cycle();
      drv_a(1, 32'h8, 0, 0, SZ16, 0);
      drv_b(1, 32'hC, 0, 0, SZ8, 1, 0);
      @(negedge clk);
      chk("sim_c0_a_gnt", 32'(a_gnt), 1);
      chk("sim_c0_b_gnt", 32'(b_gnt), 0);
      chk("sim_c0_mem_size", 32'(mem_size), 32'(SZ16));
      next_cycle();
      drv_a(0, 0, 0, 0, SZ32, 0);
      @(negedge clk);
      chk("sim_c1_a_rvalid", 32'(a_rvalid), 1);
      chk("sim_c1_a_rdata", a_rdata, 32'hFFFF_8000);
      chk("sim_c1_b_gnt", 32'(b_gnt), 1);
      chk("sim_c1_b_rvalid", 32'(b_rvalid), 0);
      chk("sim_c1_uns", 32'(mem_load_unsigned), 1);
      next_cycle();
      drv_b(0, 0, 0, 0, SZ32, 0, 0);
      @(negedge clk);
      chk("sim_c2_b_rvalid", 32'(b_rvalid), 1);
      chk("sim_c2_b_rdata", b_rdata, 32'h0000_0080);
      chk("sim_c2_a_rvalid", 32'(a_rvalid), 0);
      chk("sim_c2_a_rdata", a_rdata, 0);

      // Starvation: B forced through every fifth cycle
      exp_b = 10'b10_0001_0000;
      for (int i = 0; i < 10; i++) begin
         next_cycle();
         drv_a(1, 32'h10, 0, 0, SZ32, 0);
         drv_b(1, 32'h10, 0, 0, SZ32, 0, 0);
         @(negedge clk);
         chk($sformatf("starve_c%0d_b_gnt", i), 32'(b_gnt), 32'(exp_b[i]));
         chk($sformatf("starve_c%0d_a_gnt", i), 32'(a_gnt), 32'(!exp_b[i]));
      end
      next_cycle();
      drv_a(0, 0, 0, 0, SZ32, 0);
      drv_b(0, 0, 0, 0, SZ32, 0, 0);

      // Lock: three B stores hold off A; A gets in after the lock drops
      next_cycle();
      drv_b(1, 32'h20, 32'h1111_1111, 1, SZ32, 0, 1);
      @(negedge clk);
      chk("lock_c0_b_gnt", 32'(b_gnt), 1);
      next_cycle();
      drv_a(1, 32'h10, 0, 0, SZ32, 0);
      drv_b(1, 32'h24, 32'h2222_2222, 1, SZ32, 0, 1);
      @(negedge clk);
      chk("lock_c1_b_gnt", 32'(b_gnt), 1);
      chk("lock_c1_a_gnt", 32'(a_gnt), 0);
      next_cycle();
      drv_b(1, 32'h28, 32'h3333_3333, 1, SZ32, 0, 0);
      @(negedge clk);
      chk("lock_c2_b_gnt", 32'(b_gnt), 1);
      chk("lock_c2_a_gnt", 32'(a_gnt), 0);
      next_cycle();
      drv_b(0, 0, 0, 0, SZ32, 0, 0);
      @(negedge clk);
      chk("lock_c3_a_gnt", 32'(a_gnt), 1);
      chk("lock_c3_b_gnt", 32'(b_gnt), 0);

      // Lock held with no B request: no grant, then back to IDLE
      next_cycle();
      drv_a(0, 0, 0, 0, SZ32, 0);
      drv_b(1, 32'h30, 32'h4444_4444, 1, SZ32, 0, 1);
      @(negedge clk);
      chk("lk2_c0_b_gnt", 32'(b_gnt), 1);
      next_cycle();
      drv_a(1, 32'h10, 0, 0, SZ32, 0);
      drv_b(0, 0, 0, 0, SZ32, 0, 1);
      @(negedge clk);
      chk("lk2_c1_a_gnt", 32'(a_gnt), 0);
      chk("lk2_c1_b_gnt", 32'(b_gnt), 0);
      chk("lk2_c1_mem_en", 32'(mem_en), 0);
      next_cycle();
      drv_b(0, 0, 0, 0, SZ32, 0, 0);
      @(negedge clk);
      chk("lk2_c2_a_gnt", 32'(a_gnt), 1);

      // Reset in the middle of a locked B load sequence
      next_cycle();
      drv_a(0, 0, 0, 0, SZ32, 0);
      drv_b(1, 32'h10, 0, 0, SZ32, 0, 1);
      @(negedge clk);
      chk("rl_c0_b_gnt", 32'(b_gnt), 1);
      next_cycle();
      @(negedge clk);
      chk("rl_c1_b_gnt", 32'(b_gnt), 1);
      chk("rl_c1_b_rvalid", 32'(b_rvalid), 1);
      chk("rl_c1_b_rdata", b_rdata, 32'hDEADBEEF);
      next_cycle();
      rst = 1'b1;
      @(negedge clk);
      chk("rl_rst_b_rvalid", 32'(b_rvalid), 0);
      chk("rl_rst_b_rdata", b_rdata, 0);
      chk("rl_rst_b_gnt", 32'(b_gnt), 0);
      next_cycle();
      rst = 1'b0;
      drv_b(0, 0, 0, 0, SZ32, 0, 0);
      drv_a(1, 32'h10, 0, 0, SZ32, 0);
      @(negedge clk);
      chk("rl_post_a_gnt", 32'(a_gnt), 1);
      chk("rl_post_b_rvalid", 32'(b_rvalid), 0);
      next_cycle();
      drv_a(0, 0, 0, 0, SZ32, 0);
      @(negedge clk);
      chk("rl_post_a_rvalid", 32'(a_rvalid), 1);
      chk("rl_post_a_rdata", a_rdata, 32'hDEADBEEF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single data-memory instance (`memory`) between two requesters.
- Port A is the pipeline MEM stage. Port B is the loader/debug DMA port.
- Uses fixed priority to A, plus a starvation counter that guarantees B forward progress, plus a B-side lock for multi-beat bursts.
- Sits between the requesters and `memory`, and steers the registered read data back to whichever requester owns it.

Parameters:
- XLEN, 32, data/address width.
- STARVE_LIMIT, 4, max consecutive A grants while B is requesting before B is forced through (range 1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- a_req  in  1  A requests an access this cycle.
- a_addr  in  XLEN  A byte address.
- a_wdata  in  XLEN  A write data.
- a_write  in  1  1=store, 0=load.
- a_size  in  2  access size, `SIZE_8/`SIZE_16/`SIZE_32 encoding.
- a_unsigned  in  1  zero-extend load.
- a_gnt  out  1  A access issued to memory this cycle.
- a_rvalid  out  1  a_rdata valid this cycle.
- a_rdata  out  XLEN  load result for A.
- b_req, b_addr, b_wdata, b_write, b_size, b_unsigned  in  as for A.
- b_lock  in  1  B requests to hold ownership across consecutive cycles.
- b_gnt, b_rvalid, b_rdata  out  as for A.
- mem_en  out  1  drives memory.en.
- mem_addr  out  XLEN  drives memory.addr.
- mem_write_data  out  XLEN  drives memory.write_data.
- mem_write  out  1  drives memory.write.
- mem_size  out  2  drives memory.size.
- mem_load_unsigned  out  1  drives memory.load_unsigned.
- mem_read_data  in  XLEN  from memory.read_data; valid 1 cycle after a granted load.

Behaviour:
- Interface: one clock (clk); rst is synchronous and active-high.
- Reset values:
  - state=IDLE, starve_cnt=0.
  - a_rvalid=b_rvalid=0, a_rdata=b_rdata=0.
  - With no requests, all mem_* outputs are 0.
- Grant is combinational in the request cycle. Memory outputs are muxed from the winner:
  - mem_en = a_gnt | b_gnt.
  - With no grant, mem_write=0 and mem_addr/mem_write_data/mem_size/mem_load_unsigned=0.
  - a_gnt and b_gnt are never both 1.
- States:
  - IDLE (normal arbitration).
  - B_LOCK: B owns memory; a_gnt=0 regardless of a_req.
- IDLE arbitration:
  - If b_req & starve_cnt==STARVE_LIMIT: b_gnt=1.
  - Else if a_req: a_gnt=1.
  - Else if b_req: b_gnt=1.
- IDLE -> B_LOCK when b_gnt & b_lock at the clock edge.
- B_LOCK behaviour:
  - b_gnt = b_req.
  - Stays in B_LOCK while b_req & b_lock; otherwise -> IDLE at the edge.
  - If b_lock is high but b_req is low, the block returns to IDLE and does not grant.
- starve_cnt, updated at each edge:
  - Set to 0 if b_gnt, or if !b_req, or in B_LOCK.
  - Else +1 if a_gnt, saturating at STARVE_LIMIT.
  - Else held.
- Read return:
  - Registered owner tags: a_rvalid <= a_gnt & !a_write; b_rvalid <= b_gnt & !b_write.
  - a_rdata = mem_read_data when a_rvalid, else 0 (same rule for B).
  - Latency is exactly 1 cycle after grant. Back-to-back loads from alternating ports are legal; each result goes only to its owner.
- Stores produce no rvalid. A store granted in cycle N is visible to a load granted in cycle N+1.
- Requesters hold their request fields stable until they see gnt. The arbiter does not latch request fields.
- Reset mid-operation (including in B_LOCK or with a load outstanding):
  - Returns to IDLE.
  - Outstanding rvalid is dropped; it is not delivered after reset.

Test Plan:
- Reset: assert rst 2 cycles with a_req=b_req=1 -> a_gnt=b_gnt=0, mem_en=0, rvalid=0, starve_cnt=0 throughout.
- Cross-port coherence:
  - B stores 0xDEADBEEF to 0x10 (`SIZE_32) with A idle -> b_gnt=1 that cycle.
  - Next cycle A loads 0x10 -> a_gnt=1, then a_rvalid=1 with a_rdata=0xDEADBEEF one cycle later; b_rvalid stays 0.
- Simultaneous loads:
  - Setup: memory holds 0x8000 at 8 and 0x80 at 12.
  - A loads 8 (`SIZE_16, signed) and B loads 12 (`SIZE_8, unsigned), both requesting in cycle 0.
  - Cycle 0 -> A granted. Cycle 1 -> a_rvalid with 0xFFFF_8000; B granted.
  - Cycle 2 -> b_rvalid with 0x0000_0080.
- Starvation (STARVE_LIMIT=4): a_req and b_req held high from cycle 0 -> a_gnt in cycles 0-3, b_gnt in cycle 4, a_gnt in cycles 5-8, b_gnt in cycle 9.
- Lock: B issues 3 stores with b_lock=1 while a_req=1 -> b_gnt for 3 consecutive cycles with a_gnt=0; a_gnt=1 in the cycle after b_lock drops.
- Reset mid-lock: B_LOCK with a B load granted in cycle N, rst=1 in cycle N+1 -> b_rvalid=0 in N+1; after rst drops, A is granted on its first request.
